// File: rtl/sqrt_result_reorder.sv
// sqrt_result_reorder
//
// Reorder buffer that collects results from the sqrt formula worker pool.
// Workers can have different latencies, so results may come back in any order.
// Each accepted argument triple gets an in-order tag. Finished results are
// stored against their tag, and they leave through a registered valid/ready
// output strictly in the order the tags were issued.
//
// Optional feature (macro SQRT_ROB_ERR_CHECK_EN):
//   When the macro is defined, the block checks each completion and adds a
//   sticky "err" output. A completion is illegal if its tag is not allocated
//   or its tag is already done. Illegal completions are dropped and set err.
//   When the macro is undefined, every completion is written unconditionally.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   issue_vld  upstream requests a tag for a new argument triple
//   issue_rdy  a free entry exists (count < DEPTH), combinational
//   issue_tag  tag handed out when issue_vld && issue_rdy
//   cpl_vld    a worker presents a finished result
//   cpl_tag    tag of that result
//   cpl_res    result value
//   res_vld    registered, an in-order result is available
//   res_rdy    downstream accepts res this cycle
//   res        registered in-order result
//   err        (SQRT_ROB_ERR_CHECK_EN only) sticky illegal-completion flag

module sqrt_result_reorder #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_vld,
    output logic              issue_rdy,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cpl_vld,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [DATA_W-1:0] cpl_res,
    output logic              res_vld,
    input  logic              res_rdy,
`ifdef SQRT_ROB_ERR_CHECK_EN
    output logic [DATA_W-1:0] res,
    output logic              err
`else
    output logic [DATA_W-1:0] res
`endif
);

    logic [TAG_W-1:0]  wr_ptr;
    logic [TAG_W-1:0]  rd_ptr;
    logic [TAG_W:0]    count;
    logic [DEPTH-1:0]  alloc;
    logic [DEPTH-1:0]  done;
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic issue_fire;
    logic cpl_ok;
    logic cpl_fire;
    logic pop;

    assign issue_rdy  = (count < (TAG_W+1)'(DEPTH));
    assign issue_tag  = wr_ptr;
    assign issue_fire = issue_vld && issue_rdy;

`ifdef SQRT_ROB_ERR_CHECK_EN
    // A tag being issued this cycle still reads alloc=0, so a completion
    // that lands in the same cycle counts as illegal.
    assign cpl_ok = alloc[cpl_tag] && !done[cpl_tag];
`else
    assign cpl_ok = 1'b1;
`endif
    assign cpl_fire = cpl_vld && cpl_ok;

    // Qualifying the pop with alloc keeps an empty buffer from popping, even
    // if a stray completion has set a done bit on a free entry.
    assign pop = alloc[rd_ptr] && done[rd_ptr] && (!res_vld || res_rdy);

    // Entry status. Issue and pop never target the same entry. When the
    // buffer is full, issue_rdy is 0. When it is empty, alloc[rd_ptr] is 0.
    // The pop is applied last, so it wins over a duplicate completion of the
    // head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc <= '0;
            done  <= '0;
        end else begin
            if (cpl_fire) begin
                done[cpl_tag] <= 1'b1;
            end
            if (issue_fire) begin
                alloc[wr_ptr] <= 1'b1;
                done[wr_ptr]  <= 1'b0;
            end
            if (pop) begin
                alloc[rd_ptr] <= 1'b0;
                done[rd_ptr]  <= 1'b0;
            end
        end
    end

    // The payload needs no reset. It is only read once its done bit is set.
    always_ff @(posedge clk) begin
        if (cpl_fire) begin
            data_mem[cpl_tag] <= cpl_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (issue_fire) begin
                wr_ptr <= wr_ptr + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TAG_W'(1);
            end
            if (issue_fire && !pop) begin
                count <= count + (TAG_W+1)'(1);
            end else if (!issue_fire && pop) begin
                count <= count - (TAG_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld <= 1'b0;
            res     <= '0;
        end else if (pop) begin
            res_vld <= 1'b1;
            res     <= data_mem[rd_ptr];
        end else if (res_rdy) begin
            res_vld <= 1'b0;
        end
    end

`ifdef SQRT_ROB_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (cpl_vld && !cpl_ok) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_result_reorder.sv
// Directed self-checking bench for sqrt_result_reorder (DEPTH=32, DATA_W=32).
// Define SQRT_ROB_ERR_CHECK_EN to also exercise the err output.

module tb_sqrt_result_reorder;

    localparam int DEPTH  = 32;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_vld;
    logic              issue_rdy;
    logic [TAG_W-1:0]  issue_tag;
    logic              cpl_vld;
    logic [TAG_W-1:0]  cpl_tag;
    logic [DATA_W-1:0] cpl_res;
    logic              res_vld;
    logic              res_rdy;
    logic [DATA_W-1:0] res;
`ifdef SQRT_ROB_ERR_CHECK_EN
    logic              err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sqrt_result_reorder #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .issue_vld (issue_vld),
        .issue_rdy (issue_rdy),
        .issue_tag (issue_tag),
        .cpl_vld   (cpl_vld),
        .cpl_tag   (cpl_tag),
        .cpl_res   (cpl_res),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
`ifdef SQRT_ROB_ERR_CHECK_EN
        .res       (res),
        .err       (err)
`else
        .res       (res)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        issue_vld = 1'b0;
        cpl_vld   = 1'b0;
        cpl_tag   = '0;
        cpl_res   = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        res_rdy = 1'b0;
        do_reset();
        n_tests++;
        if (issue_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_issue_rdy: got %0b exp 1", issue_rdy); end
        n_tests++;
        if (issue_tag !== 5'd0) begin n_fail++; $display("FAIL reset_issue_tag: got %0d exp 0", issue_tag); end
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_res_vld: got %0b exp 0", res_vld); end
        n_tests++;
        if (res !== 32'd0) begin n_fail++; $display("FAIL reset_res: got %0d exp 0", res); end
`ifdef SQRT_ROB_ERR_CHECK_EN
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b exp 0", err); end
`endif
    endtask

    task automatic test_out_of_order();
        do_reset();
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_vld = 1'b1;
            n_tests++;
            if (issue_tag !== TAG_W'(i)) begin n_fail++; $display("FAIL ooo_issue_tag: got %0d exp %0d", issue_tag, i); end
            step();
        end
        issue_vld = 1'b0;
        cpl_vld = 1'b1; cpl_tag = 5'd3; cpl_res = 32'd30;
        step();
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_early_vld_a: got %0b exp 0", res_vld); end
        cpl_tag = 5'd1; cpl_res = 32'd10;
        step();
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_early_vld_b: got %0b exp 0", res_vld); end
        cpl_tag = 5'd0; cpl_res = 32'd0;
        step();
        // head is done but not yet in the output register
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_head_latency: got %0b exp 0", res_vld); end
        cpl_tag = 5'd2; cpl_res = 32'd20;
        step();
        cpl_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (res_vld !== 1'b1 || res !== 32'(k * 10)) begin
                n_fail++; $display("FAIL ooo_res_%0d: got vld=%0b res=%0d exp vld=1 res=%0d", k, res_vld, res, k * 10);
            end
            step();
        end
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL ooo_drain: got %0b exp 0", res_vld); end
        n_tests++;
        if (issue_tag !== 5'd4) begin n_fail++; $display("FAIL ooo_next_tag: got %0d exp 4", issue_tag); end
    endtask

    task automatic test_full_and_backpressure();
        do_reset();
        res_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_vld = 1'b1;
            n_tests++;
            if (issue_rdy !== 1'b1 || issue_tag !== TAG_W'(i)) begin
                n_fail++; $display("FAIL fill_%0d: got rdy=%0b tag=%0d exp rdy=1 tag=%0d", i, issue_rdy, issue_tag, i);
            end
            step();
        end
        n_tests++;
        if (issue_rdy !== 1'b0 || issue_tag !== 5'd0) begin
            n_fail++; $display("FAIL full_state: got rdy=%0b tag=%0d exp rdy=0 tag=0", issue_rdy, issue_tag);
        end
        step();
        n_tests++;
        if (issue_rdy !== 1'b0 || issue_tag !== 5'd0) begin
            n_fail++; $display("FAIL full_ignore_issue: got rdy=%0b tag=%0d exp rdy=0 tag=0", issue_rdy, issue_tag);
        end
        issue_vld = 1'b0;
        cpl_vld = 1'b1; cpl_tag = 5'd0; cpl_res = 32'd100;
        step();
        cpl_vld = 1'b0;
        n_tests++;
        if (issue_rdy !== 1'b0) begin n_fail++; $display("FAIL full_before_pop: got %0b exp 0", issue_rdy); end
        step();
        n_tests++;
        if (res_vld !== 1'b1 || res !== 32'd100 || issue_rdy !== 1'b1) begin
            n_fail++; $display("FAIL full_pop0: got vld=%0b res=%0d rdy=%0b exp vld=1 res=100 rdy=1", res_vld, res, issue_rdy);
        end
        cpl_vld = 1'b1; cpl_tag = 5'd1; cpl_res = 32'd101;
        issue_vld = 1'b1;
        n_tests++;
        if (issue_tag !== 5'd0) begin n_fail++; $display("FAIL full_reissue_tag: got %0d exp 0", issue_tag); end
        step();
        cpl_vld = 1'b0;
        issue_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (res_vld !== 1'b1 || res !== 32'd100 || issue_rdy !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: got vld=%0b res=%0d rdy=%0b exp vld=1 res=100 rdy=0", i, res_vld, res, issue_rdy);
            end
            step();
        end
        res_rdy = 1'b1;
        step();
        n_tests++;
        if (res_vld !== 1'b1 || res !== 32'd101 || issue_rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: got vld=%0b res=%0d rdy=%0b exp vld=1 res=101 rdy=1", res_vld, res, issue_rdy);
        end
        step();
        n_tests++;
        if (res_vld !== 1'b0) begin n_fail++; $display("FAIL bp_empty_after: got %0b exp 0", res_vld); end
        res_rdy = 1'b0;
    endtask

    task automatic test_stream();
        int iss_cyc [512];
        int n_iss = 0;
        int n_cpl = 0;
        int n_rx  = 0;
        int cyc   = 0;
        bit saw_stall = 1'b0;
        do_reset();
        res_rdy = 1'b1;
        while (cyc < 450 && !(cyc >= 300 && n_rx == n_iss)) begin
            if (res_vld === 1'b1) begin
                n_tests++;
                if (res !== 32'(n_rx * 3 + 7)) begin
                    n_fail++; $display("FAIL stream_res_%0d: got %0d exp %0d", n_rx, res, n_rx * 3 + 7);
                end
                n_rx++;
            end
            issue_vld = (cyc < 300);
            cpl_vld = 1'b0;
            if (issue_vld && !issue_rdy) saw_stall = 1'b1;
            if (issue_vld && issue_rdy) begin
                n_tests++;
                if (issue_tag !== TAG_W'(n_iss)) begin
                    n_fail++; $display("FAIL stream_tag_%0d: got %0d exp %0d", n_iss, issue_tag, n_iss % DEPTH);
                end
                iss_cyc[n_iss] = cyc;
                n_iss++;
            end
            if (n_cpl < n_iss && iss_cyc[n_cpl] + 50 == cyc) begin
                cpl_vld = 1'b1;
                cpl_tag = TAG_W'(n_cpl);
                cpl_res = 32'(n_cpl * 3 + 7);
                n_cpl++;
            end
            step();
            cyc++;
        end
        issue_vld = 1'b0;
        cpl_vld = 1'b0;
        n_tests++;
        if (n_rx != n_iss || n_iss < 100) begin
            n_fail++; $display("FAIL stream_count: got rx=%0d exp rx=issued=%0d (>=100)", n_rx, n_iss);
        end
        n_tests++;
        if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL stream_full_stall: got %0b exp 1", saw_stall); end
        res_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_rdy = 1'b1;
        issue_vld = 1'b1;
        for (int i = 0; i < 7; i++) step();
        issue_vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (issue_tag !== 5'd0 || issue_rdy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state: got tag=%0d rdy=%0b exp tag=0 rdy=1", issue_tag, issue_rdy);
        end
        cpl_vld = 1'b1; cpl_tag = 5'd2; cpl_res = 32'd222;
        step();
        cpl_tag = 5'd5; cpl_res = 32'd555;
        step();
        cpl_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (res_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_no_vld_%0d: got %0b exp 0", i, res_vld); end
            step();
        end
`ifdef SQRT_ROB_ERR_CHECK_EN
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL midrst_err: got %0b exp 1", err); end
`endif
        res_rdy = 1'b0;
    endtask

`ifdef SQRT_ROB_ERR_CHECK_EN
    task automatic test_dup_completion();
        int got = 0;
        logic [DATA_W-1:0] exp_vals [5];
        exp_vals[0] = 32'd0; exp_vals[1] = 32'd1; exp_vals[2] = 32'd2;
        exp_vals[3] = 32'd3; exp_vals[4] = 32'd44;
        do_reset();
        res_rdy = 1'b0;
        issue_vld = 1'b1;
        for (int i = 0; i < 5; i++) step();
        issue_vld = 1'b0;
        cpl_vld = 1'b1; cpl_tag = 5'd4; cpl_res = 32'd44;
        step();
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL dup_err_first: got %0b exp 0", err); end
        cpl_res = 32'd99;
        step();
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL dup_err_second: got %0b exp 1", err); end
        for (int i = 0; i < 4; i++) begin
            cpl_tag = TAG_W'(i); cpl_res = 32'(i);
            step();
        end
        cpl_vld = 1'b0;
        res_rdy = 1'b1;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (res_vld === 1'b1) begin
                n_tests++;
                if (res !== exp_vals[got]) begin n_fail++; $display("FAIL dup_res_%0d: got %0d exp %0d", got, res, exp_vals[got]); end
                got++;
            end
            step();
        end
        n_tests++;
        if (got != 5) begin n_fail++; $display("FAIL dup_res_count: got %0d exp 5", got); end
        n_tests++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL dup_err_sticky: got %0b exp 1", err); end
        res_rdy = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; issue_vld = 1'b0; cpl_vld = 1'b0; cpl_tag = '0; cpl_res = '0; res_rdy = 1'b0;
        test_reset();
        test_out_of_order();
        test_full_and_backpressure();
        test_stream();
        test_reset_mid();
`ifdef SQRT_ROB_ERR_CHECK_EN
        test_dup_completion();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
